// File: rtl/csr_trap_regs_if.sv
// CSR access bus for csr_trap_regs: request handshake plus registered response.
// The master issues requests, and the slave (the CSR block) returns one response per request.
interface csr_trap_regs_if;
    logic        csr_req_valid;
    logic        csr_req_ready;
    logic        csr_req_wen;
    logic [1:0]  csr_req_op;
    logic [11:0] csr_req_addr;
    logic [31:0] csr_req_wdata;
    logic        csr_rsp_valid;
    logic [31:0] csr_rsp_rdata;
    logic        csr_rsp_illegal;

    modport master (
        output csr_req_valid, csr_req_wen, csr_req_op, csr_req_addr, csr_req_wdata,
        input  csr_req_ready, csr_rsp_valid, csr_rsp_rdata, csr_rsp_illegal
    );

    modport slave (
        input  csr_req_valid, csr_req_wen, csr_req_op, csr_req_addr, csr_req_wdata,
        output csr_req_ready, csr_rsp_valid, csr_rsp_rdata, csr_rsp_illegal
    );
endinterface

// File: rtl/csr_trap_regs.sv
// Machine-mode trap CSRs (mstatus, mtvec, mscratch, mepc, mcause, mtval) with a
// single-cycle CSR access port and trap/mret commit updates.
module csr_trap_regs #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        excpcmt_i_cause_ena,
    input  logic [31:0] excpcmt_i_cause,
    input  logic        excpcmt_i_badaddr_ena,
    input  logic [31:0] excpcmt_i_badaddr,
    input  logic        excpcmt_i_epc_ena,
    input  logic [31:0] excpcmt_i_epc,
    input  logic        excpcmt_i_status_ena,
    input  logic        mret_ena,
    csr_trap_regs_if.slave bus,
    output logic [31:0] csr_mtvec,
    output logic [31:0] csr_mepc,
    output logic        status_mie
);
    localparam int unsigned XLEN = 32;

    logic            mie_q, mie_d, mpie_q, mpie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_illegal_q, rsp_illegal_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;

    logic            commit, ready, accept, hit, legal, wr;
    logic [XLEN-1:0] mstatus_rd, old_val, new_val;

    // MPP is hardwired to machine mode; only MIE and MPIE hold state.
    assign mstatus_rd = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};

    assign commit = excpcmt_i_cause_ena | excpcmt_i_badaddr_ena | excpcmt_i_epc_ena |
                    excpcmt_i_status_ena | mret_ena;
    assign ready  = ~commit;
    assign accept = bus.csr_req_valid & ready;

    always_comb begin
        hit     = 1'b1;
        old_val = '0;
        case (bus.csr_req_addr)
            12'h300: old_val = mstatus_rd;
            12'h305: old_val = mtvec_q;
            12'h340: old_val = mscratch_q;
            12'h341: old_val = mepc_q;
            12'h342: old_val = mcause_q;
            12'h343: old_val = mtval_q;
            default: hit = 1'b0;
        endcase
    end

    always_comb begin
        case (bus.csr_req_op)
            2'b01:   new_val = old_val | bus.csr_req_wdata;
            2'b10:   new_val = old_val & ~bus.csr_req_wdata;
            default: new_val = bus.csr_req_wdata;
        endcase
    end

    assign legal = hit & (bus.csr_req_op != 2'b11);
    assign wr    = accept & bus.csr_req_wen & legal;

    always_comb begin
        mie_d         = mie_q;
        mpie_d        = mpie_q;
        mtvec_d       = mtvec_q;
        mscratch_d    = mscratch_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
        mtval_d       = mtval_q;
        rsp_valid_d   = accept;
        rsp_illegal_d = accept & ~legal;
        rsp_rdata_d   = rsp_rdata_q;
        if (accept) begin
            rsp_rdata_d = legal ? old_val : '0;
        end

        if (wr) begin
            case (bus.csr_req_addr)
                12'h300: begin
                    mie_d  = new_val[3];
                    mpie_d = new_val[7];
                end
                12'h305: mtvec_d    = {new_val[31:2], 2'b00};
                12'h340: mscratch_d = new_val;
                12'h341: mepc_d     = {new_val[31:1], 1'b0};
                12'h342: mcause_d   = new_val;
                12'h343: mtval_d    = new_val;
                default: ;
            endcase
        end

        // Any commit input holds off CSR acceptance, so these never collide with wr.
        if (excpcmt_i_cause_ena)   mcause_d = excpcmt_i_cause;
        if (excpcmt_i_badaddr_ena) mtval_d  = excpcmt_i_badaddr;
        if (excpcmt_i_epc_ena)     mepc_d   = {excpcmt_i_epc[31:1], 1'b0};
        if (excpcmt_i_status_ena) begin
            mpie_d = mie_q;
            mie_d  = 1'b0;
        end else if (mret_ena) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_q         <= 1'b0;
            mpie_q        <= 1'b0;
            mtvec_q       <= {MTVEC_RESET[31:2], 2'b00};
            mscratch_q    <= '0;
            mepc_q        <= '0;
            mcause_q      <= '0;
            mtval_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_illegal_q <= 1'b0;
            rsp_rdata_q   <= '0;
        end else begin
            mie_q         <= mie_d;
            mpie_q        <= mpie_d;
            mtvec_q       <= mtvec_d;
            mscratch_q    <= mscratch_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            mtval_q       <= mtval_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_illegal_q <= rsp_illegal_d;
            rsp_rdata_q   <= rsp_rdata_d;
        end
    end

    assign bus.csr_req_ready   = ready;
    assign bus.csr_rsp_valid   = rsp_valid_q;
    assign bus.csr_rsp_illegal = rsp_illegal_q;
    assign bus.csr_rsp_rdata   = rsp_rdata_q;
    assign csr_mtvec           = mtvec_q;
    assign csr_mepc            = mepc_q;
    assign status_mie          = mie_q;
endmodule
